// File: rtl/frame_splice_pkg.sv
// frame_splice_pkg: shared flag constants, FSM encoding and width helpers
// for the frame_splice_wide word assembler.
package frame_splice_pkg;

   localparam logic [1:0] FLAG_SINGLE = 2'b00;
   localparam logic [1:0] FLAG_HEAD   = 2'b01;
   localparam logic [1:0] FLAG_TAIL   = 2'b10;
   localparam logic [1:0] FLAG_MID    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_TRAN    = 2'b01,
      ST_DISCARD = 2'b10
   } state_t;

   function automatic int calc_iw(int out_bytes);
      return $clog2(out_bytes);
   endfunction

   function automatic int calc_ew(int in_bytes);
      return (in_bytes > 1) ? $clog2(in_bytes) : 1;
   endfunction

   function automatic int calc_pkt_w(int out_bytes);
      return 2 + $clog2(out_bytes) + 8 * out_bytes;
   endfunction

endpackage

// File: rtl/frame_splice_wide_if.sv
// frame_splice_wide_if: beat input and packet word output bundle
// of the frame_splice_wide assembler.
interface frame_splice_wide_if #(
   parameter int IN_BYTES  = 1,
   parameter int OUT_BYTES = 16
);
   import frame_splice_pkg::*;

   localparam int EW    = calc_ew(IN_BYTES);
   localparam int PKT_W = calc_pkt_w(OUT_BYTES);

   logic                  i_data_wr;
   logic                  i_sop;
   logic                  i_eop;
   logic [8*IN_BYTES-1:0] iv_data;
   logic [EW-1:0]         iv_empty;

   logic                  o_pkt_wr;
   logic [PKT_W-1:0]      ov_pkt;
   logic                  o_pkt_err;
   logic [15:0]           ov_err_cnt;
   logic [1:0]            ov_state;

   modport master (
      output i_data_wr, i_sop, i_eop, iv_data, iv_empty,
      input  o_pkt_wr, ov_pkt, o_pkt_err, ov_err_cnt, ov_state
   );

   modport slave (
      input  i_data_wr, i_sop, i_eop, iv_data, iv_empty,
      output o_pkt_wr, ov_pkt, o_pkt_err, ov_err_cnt, ov_state
   );

endinterface

// File: rtl/splice_lane_mux.sv
// splice_lane_mux: drops one beat into its lane of the accumulator and
// zeroes the bytes past the valid count on a tail word.
module splice_lane_mux
   import frame_splice_pkg::*;
#(
   parameter int IN_BYTES  = 1,
   parameter int OUT_BYTES = 16,
   localparam int IW       = calc_iw(OUT_BYTES)
) (
   input  logic [8*OUT_BYTES-1:0] acc,
   input  logic [8*IN_BYTES-1:0]  beat,
   input  logic [IW-1:0]          fill,
   input  logic                   tail,
   input  logic [IW:0]            valid,
   output logic [8*OUT_BYTES-1:0] merged
);

   localparam int LANES = OUT_BYTES / IN_BYTES;
   localparam int LW    = 8 * IN_BYTES;

   always_comb begin
      merged = acc;
      for (int l = 0; l < LANES; l++) begin
         if (fill == IW'(l * IN_BYTES))
            merged[LW*(LANES-1-l) +: LW] = beat;
      end
      for (int b = 0; b < OUT_BYTES; b++) begin
         if (tail && ((IW+1)'(b) >= valid))
            merged[8*(OUT_BYTES-1-b) +: 8] = 8'h00;
      end
   end

endmodule

// File: rtl/frame_splice_wide.sv
// frame_splice_wide: packs SOP/EOP-delimited beats into wide packet
// words with position flag, invalid count and truncation marking.
module frame_splice_wide
   import frame_splice_pkg::*;
#(
   parameter int IN_BYTES      = 1,
   parameter int OUT_BYTES     = 16,
   parameter int MAX_PKT_BYTES = 2047
) (
   input logic                clk_sys,
   input logic                reset_n,
   frame_splice_wide_if.slave bus
);

   localparam int IW    = calc_iw(OUT_BYTES);
   localparam int PKT_W = calc_pkt_w(OUT_BYTES);
   localparam int DW    = 8 * OUT_BYTES;
   localparam int CW    = $clog2(MAX_PKT_BYTES + 1) + 1;

   state_t           state, state_n;
   logic [DW-1:0]    acc, acc_n;
   logic [IW-1:0]    fill, fill_n;
   logic             head, head_n;
   logic [CW-1:0]    cnt, cnt_n;

   logic             pkt_wr;
   logic [PKT_W-1:0] pkt;
   logic             pkt_err;
   logic [15:0]      err_cnt;

   logic             emit, emit_err, err_inc;
   logic [1:0]       emit_flag;
   logic [IW-1:0]    emit_inv;
   logic [DW-1:0]    emit_data;

   logic [DW-1:0]    mux_acc, merged;
   logic [IW-1:0]    mux_fill;
   logic [IW:0]      end_pos, valid, tail_inv, pend_inv;
   logic             tail_mask, word_full, over;

   // an SOP beat always lands in lane 0 of a cleared accumulator
   assign mux_acc   = bus.i_sop ? '0 : acc;
   assign mux_fill  = bus.i_sop ? '0 : fill;
   assign end_pos   = {1'b0, mux_fill} + (IW+1)'(IN_BYTES);
   assign valid     = end_pos - (IW+1)'(bus.iv_empty);
   assign tail_inv  = (IW+1)'(OUT_BYTES) - valid;
   assign word_full = end_pos == (IW+1)'(OUT_BYTES);
   assign over      = (cnt + CW'(IN_BYTES)) > CW'(MAX_PKT_BYTES);
   assign tail_mask = bus.i_eop
                    & ~(state == ST_TRAN & bus.i_sop);
   assign pend_inv  = (fill == '0)
                    ? (IW+1)'(OUT_BYTES - 1)
                    : (IW+1)'(OUT_BYTES) - {1'b0, fill};

   splice_lane_mux #(
      .IN_BYTES  (IN_BYTES),
      .OUT_BYTES (OUT_BYTES)
   ) u_mux (
      .acc    (mux_acc),
      .beat   (bus.iv_data),
      .fill   (mux_fill),
      .tail   (tail_mask),
      .valid  (valid),
      .merged (merged)
   );

   always_comb begin
      state_n   = state;
      acc_n     = acc;
      fill_n    = fill;
      head_n    = head;
      cnt_n     = cnt;
      emit      = 1'b0;
      emit_err  = 1'b0;
      emit_flag = FLAG_SINGLE;
      emit_inv  = '0;
      emit_data = merged;
      err_inc   = 1'b0;
      if (bus.i_data_wr) begin
         unique case (state)
            ST_TRAN: begin
               if (bus.i_sop) begin
                  emit      = 1'b1;
                  emit_err  = 1'b1;
                  err_inc   = 1'b1;
                  emit_flag = FLAG_TAIL;
                  emit_inv  = pend_inv[IW-1:0];
                  emit_data = acc;
                  acc_n     = merged;
                  fill_n    = end_pos[IW-1:0];
                  head_n    = 1'b1;
                  cnt_n     = CW'(IN_BYTES);
               end else if (over) begin
                  emit      = 1'b1;
                  emit_err  = 1'b1;
                  err_inc   = 1'b1;
                  emit_flag = FLAG_TAIL;
                  emit_inv  = pend_inv[IW-1:0];
                  emit_data = acc;
                  acc_n     = '0;
                  fill_n    = '0;
                  head_n    = 1'b0;
                  cnt_n     = '0;
                  state_n   = bus.i_eop ? ST_IDLE : ST_DISCARD;
               end else if (bus.i_eop) begin
                  emit      = 1'b1;
                  emit_flag = head ? FLAG_SINGLE : FLAG_TAIL;
                  emit_inv  = tail_inv[IW-1:0];
                  acc_n     = '0;
                  fill_n    = '0;
                  head_n    = 1'b0;
                  cnt_n     = '0;
                  state_n   = ST_IDLE;
               end else if (word_full) begin
                  emit      = 1'b1;
                  emit_flag = head ? FLAG_HEAD : FLAG_MID;
                  acc_n     = '0;
                  fill_n    = '0;
                  head_n    = 1'b0;
                  cnt_n     = cnt + CW'(IN_BYTES);
               end else begin
                  acc_n     = merged;
                  fill_n    = end_pos[IW-1:0];
                  cnt_n     = cnt + CW'(IN_BYTES);
               end
            end
            ST_IDLE, ST_DISCARD: begin
               if (bus.i_sop && bus.i_eop) begin
                  emit      = 1'b1;
                  emit_flag = FLAG_SINGLE;
                  emit_inv  = tail_inv[IW-1:0];
                  acc_n     = '0;
                  fill_n    = '0;
                  head_n    = 1'b0;
                  cnt_n     = '0;
                  state_n   = ST_IDLE;
               end else if (bus.i_sop) begin
                  acc_n     = merged;
                  fill_n    = end_pos[IW-1:0];
                  head_n    = 1'b1;
                  cnt_n     = CW'(IN_BYTES);
                  state_n   = ST_TRAN;
               end else if (state == ST_DISCARD && bus.i_eop) begin
                  state_n   = ST_IDLE;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         acc     <= '0;
         fill    <= '0;
         head    <= 1'b0;
         cnt     <= '0;
         pkt_wr  <= 1'b0;
         pkt     <= '0;
         pkt_err <= 1'b0;
         err_cnt <= '0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         fill    <= fill_n;
         head    <= head_n;
         cnt     <= cnt_n;
         pkt_wr  <= emit;
         pkt_err <= emit & emit_err;
         if (emit)
            pkt <= {emit_flag, emit_inv, emit_data};
         if (err_inc && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
      end
   end

   assign bus.o_pkt_wr   = pkt_wr;
   assign bus.ov_pkt     = pkt;
   assign bus.o_pkt_err  = pkt_err;
   assign bus.ov_err_cnt = err_cnt;
   assign bus.ov_state   = state;

endmodule

// File: tb/tb_frame_splice_wide.sv
// tb_frame_splice_wide: table vectors, directed corner sequences and a
// random beat stream checked against a byte-list packet model.
`timescale 1ns/1ps
module tb_frame_splice_wide;
   import frame_splice_pkg::*;

   typedef struct packed {
      logic [1:0]   flag;
      logic [3:0]   inv;
      logic         err;
      logic [127:0] data;
   } word_t;

   typedef struct {
      int         len;
      int         nw;
      logic [1:0] first_flag;
      logic [1:0] last_flag;
      int         last_inv;
   } vec_t;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_sys = ~clk_sys;

   frame_splice_wide_if #(.IN_BYTES(1), .OUT_BYTES(16)) bus1();
   frame_splice_wide_if #(.IN_BYTES(1), .OUT_BYTES(16)) busm();
   frame_splice_wide_if #(.IN_BYTES(4), .OUT_BYTES(16)) bus4();

   frame_splice_wide #(
      .IN_BYTES(1), .OUT_BYTES(16), .MAX_PKT_BYTES(2047)
   ) u1 (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus1));

   frame_splice_wide #(
      .IN_BYTES(1), .OUT_BYTES(16), .MAX_PKT_BYTES(64)
   ) um (.clk_sys(clk_sys), .reset_n(reset_n), .bus(busm));

   frame_splice_wide #(
      .IN_BYTES(4), .OUT_BYTES(16), .MAX_PKT_BYTES(2047)
   ) u4 (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus4));

   assign busm.i_data_wr = bus1.i_data_wr;
   assign busm.i_sop     = bus1.i_sop;
   assign busm.i_eop     = bus1.i_eop;
   assign busm.iv_data   = bus1.iv_data;
   assign busm.iv_empty  = bus1.iv_empty;

   int checks = 0;
   int errors = 0;

   word_t q1[$], qm[$], q4[$], e1[$], em[$];

   function automatic word_t to_word(logic [133:0] p, logic e);
      word_t w;
      w.flag = p[133:132];
      w.inv  = p[131:128];
      w.data = p[127:0];
      w.err  = e;
      return w;
   endfunction

   always @(negedge clk_sys) begin
      if (bus1.o_pkt_wr === 1'b1)
         q1.push_back(to_word(bus1.ov_pkt, bus1.o_pkt_err));
      if (busm.o_pkt_wr === 1'b1)
         qm.push_back(to_word(busm.ov_pkt, busm.o_pkt_err));
      if (bus4.o_pkt_wr === 1'b1)
         q4.push_back(to_word(bus4.ov_pkt, bus4.o_pkt_err));
   end

   task automatic chk_i(string nm, int got, int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", nm, got, exp);
      end
   endtask

   task automatic chk_w(string nm, word_t got, word_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   // reference model: per-DUT list of pending packet bytes
   logic [7:0] m_pend[2][16];
   int         m_np[2];
   int         m_cnt[2];
   bit         m_in[2];
   bit         m_disc[2];
   bit         m_head[2];
   int         m_err[2];
   int         m_max[2];

   function automatic word_t m_word(int id, logic [1:0] f, bit e);
      word_t w;
      w.flag = f;
      w.err  = e;
      w.data = '0;
      for (int i = 0; i < m_np[id]; i++)
         w.data[8*(15-i) +: 8] = m_pend[id][i];
      w.inv = (m_np[id] == 0) ? 4'd15 : 4'(16 - m_np[id]);
      return w;
   endfunction

   task automatic m_bump(int id);
      if (m_err[id] < 65535) m_err[id]++;
   endtask

   task automatic m_beat(int id, bit sop, bit eop, logic [7:0] d);
      word_t w;
      bit    has;
      bit    was_in;
      has = 0;
      w = '0;
      if (sop) begin
         was_in = m_in[id];
         if (was_in) begin
            has = 1;
            w = m_word(id, FLAG_TAIL, 1);
            m_bump(id);
         end
         m_in[id] = 1;
         m_disc[id] = 0;
         m_head[id] = 1;
         m_pend[id][0] = d;
         m_np[id] = 1;
         m_cnt[id] = 1;
         if (eop && !was_in) begin
            has = 1;
            w = m_word(id, FLAG_SINGLE, 0);
            m_in[id] = 0;
            m_np[id] = 0;
         end
      end else if (m_disc[id]) begin
         if (eop) m_disc[id] = 0;
      end else if (m_in[id]) begin
         if (m_cnt[id] + 1 > m_max[id]) begin
            has = 1;
            w = m_word(id, FLAG_TAIL, 1);
            m_bump(id);
            m_in[id] = 0;
            m_disc[id] = !eop;
            m_np[id] = 0;
         end else begin
            m_pend[id][m_np[id]] = d;
            m_np[id]++;
            m_cnt[id]++;
            if (eop) begin
               has = 1;
               w = m_word(id, m_head[id] ? FLAG_SINGLE : FLAG_TAIL, 0);
               m_in[id] = 0;
               m_np[id] = 0;
            end else if (m_np[id] == 16) begin
               has = 1;
               w = m_word(id, m_head[id] ? FLAG_HEAD : FLAG_MID, 0);
               m_head[id] = 0;
               m_np[id] = 0;
            end
         end
      end
      if (has) begin
         if (id == 0) e1.push_back(w);
         else em.push_back(w);
      end
   endtask

   task automatic gap(int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic beat1(bit sop, bit eop, logic [7:0] d);
      bus1.i_data_wr = 1'b1;
      bus1.i_sop     = sop;
      bus1.i_eop     = eop;
      bus1.iv_data   = d;
      bus1.iv_empty  = '0;
      m_beat(0, sop, eop, d);
      m_beat(1, sop, eop, d);
      gap(1);
      bus1.i_data_wr = 1'b0;
      bus1.i_sop     = 1'b0;
      bus1.i_eop     = 1'b0;
   endtask

   task automatic beat4(bit sop, bit eop, logic [31:0] d, logic [1:0] e);
      bus4.i_data_wr = 1'b1;
      bus4.i_sop     = sop;
      bus4.i_eop     = eop;
      bus4.iv_data   = d;
      bus4.iv_empty  = e;
      gap(1);
      bus4.i_data_wr = 1'b0;
      bus4.i_sop     = 1'b0;
      bus4.i_eop     = 1'b0;
   endtask

   task automatic clear_q();
      q1.delete();
      qm.delete();
      q4.delete();
      e1.delete();
      em.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      gap(2);
      chk_i("rst_wr", int'(bus1.o_pkt_wr), 0);
      chk_i("rst_state", int'(bus1.ov_state), 0);
      chk_i("rst_errcnt", int'(bus1.ov_err_cnt), 0);
      chk_i("rst_pkt_zero", int'(bus1.ov_pkt == '0), 1);
      chk_i("rst_err", int'(bus1.o_pkt_err), 0);
      for (int id = 0; id < 2; id++) begin
         m_np[id] = 0;
         m_cnt[id] = 0;
         m_in[id] = 0;
         m_disc[id] = 0;
         m_head[id] = 0;
         m_err[id] = 0;
      end
      reset_n = 1'b1;
      gap(1);
      clear_q();
   endtask

   task automatic cmp_model();
      chk_i("mdl_len1", q1.size(), e1.size());
      for (int i = 0; i < q1.size() && i < e1.size(); i++)
         chk_w("mdl_word1", q1[i], e1[i]);
      chk_i("mdl_lenm", qm.size(), em.size());
      for (int i = 0; i < qm.size() && i < em.size(); i++)
         chk_w("mdl_wordm", qm[i], em[i]);
      chk_i("mdl_err1", int'(bus1.ov_err_cnt), m_err[0]);
      chk_i("mdl_errm", int'(busm.ov_err_cnt), m_err[1]);
      chk_i("mdl_statem", int'(busm.ov_state),
            m_in[1] ? 1 : (m_disc[1] ? 2 : 0));
      clear_q();
   endtask

   initial begin
      vec_t         tbl[6];
      word_t        w;
      logic [127:0] ramp;
      ramp = 128'h000102030405060708090a0b0c0d0e0f;
      m_max[0] = 2047;
      m_max[1] = 64;
      bus1.i_data_wr = 0; bus1.i_sop = 0; bus1.i_eop = 0;
      bus1.iv_data = '0; bus1.iv_empty = '0;
      bus4.i_data_wr = 0; bus4.i_sop = 0; bus4.i_eop = 0;
      bus4.iv_data = '0; bus4.iv_empty = '0;
      #1;
      do_reset();

      tbl[0] = '{64, 4, 2'b01, 2'b10, 0};
      tbl[1] = '{20, 2, 2'b01, 2'b10, 12};
      tbl[2] = '{5, 1, 2'b00, 2'b00, 11};
      tbl[3] = '{16, 1, 2'b00, 2'b00, 0};
      tbl[4] = '{17, 2, 2'b01, 2'b10, 15};
      tbl[5] = '{1, 1, 2'b00, 2'b00, 15};
      foreach (tbl[v]) begin
         for (int i = 0; i < tbl[v].len; i++)
            beat1(i == 0, i == tbl[v].len - 1, 8'(i));
         gap(2);
         chk_i("tbl_nwords", q1.size(), tbl[v].nw);
         chk_i("tbl_first_flag", int'(q1[0].flag), int'(tbl[v].first_flag));
         chk_i("tbl_last_flag", int'(q1[q1.size()-1].flag),
               int'(tbl[v].last_flag));
         chk_i("tbl_last_inv", int'(q1[q1.size()-1].inv), tbl[v].last_inv);
         if (tbl[v].len >= 16)
            chk_i("tbl_first_data", int'(q1[0].data == ramp), 1);
         cmp_model();
      end

      // 4-byte beats, gap after beat 2, 18 bytes total
      for (int k = 0; k < 5; k++) begin
         beat4(k == 0, k == 4,
               {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)},
               (k == 4) ? 2'd2 : 2'd0);
         if (k == 1) gap(3);
      end
      gap(2);
      chk_i("w4_nwords", q4.size(), 2);
      w = '{flag: 2'b01, inv: 4'd0, err: 1'b0, data: ramp};
      chk_w("w4_head", q4[0], w);
      w = '{flag: 2'b10, inv: 4'd14, err: 1'b0,
            data: {16'h1011, 112'h0}};
      chk_w("w4_tail", q4[1], w);
      chk_i("w4_errcnt", int'(bus4.ov_err_cnt), 0);
      clear_q();

      // SOP interrupts packet A after 20 bytes
      do_reset();
      for (int i = 0; i < 20; i++) beat1(i == 0, 1'b0, 8'(8'h40 + i));
      for (int i = 0; i < 16; i++) beat1(i == 0, i == 15, 8'(8'h80 + i));
      gap(2);
      chk_i("sop_nwords", q1.size(), 3);
      w = '{flag: 2'b10, inv: 4'd12, err: 1'b1,
            data: {32'h50515253, 96'h0}};
      chk_w("sop_trunc_tail", q1[1], w);
      chk_i("sop_b_flag", int'(q1[2].flag), 0);
      chk_i("sop_b_inv", int'(q1[2].inv), 0);
      chk_i("sop_b_err", int'(q1[2].err), 0);
      chk_i("sop_errcnt", int'(bus1.ov_err_cnt), 1);
      cmp_model();

      // oversize on the 64-byte-limit instance
      do_reset();
      for (int i = 0; i < 80; i++) beat1(i == 0, i == 79, 8'(i));
      gap(2);
      chk_i("ovs_nwords", qm.size(), 5);
      chk_i("ovs_mid_flag", int'(qm[3].flag), 3);
      w = '{flag: 2'b10, inv: 4'd15, err: 1'b1, data: 128'h0};
      chk_w("ovs_zero_tail", qm[4], w);
      chk_i("ovs_state", int'(busm.ov_state), 0);
      chk_i("ovs_errcnt", int'(busm.ov_err_cnt), 1);
      chk_i("ovs_big_tail_inv", int'(q1[4].inv), 0);
      cmp_model();

      // reset in the middle of a packet
      for (int i = 0; i < 9; i++) beat1(i == 0, 1'b0, 8'(i));
      gap(2);
      chk_i("mid_state_pre", int'(bus1.ov_state), 1);
      chk_i("mid_no_partial", q1.size(), 0);
      do_reset();
      gap(3);
      chk_i("mid_no_out", q1.size(), 0);
      chk_i("mid_state", int'(bus1.ov_state), 0);

      // random beat stream against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) != 0)
            beat1($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                  8'($urandom));
         else
            gap(1);
      end
      beat1(1'b0, 1'b1, 8'h00);
      gap(2);
      cmp_model();

      // saturating error counter
      do_reset();
      for (int i = 0; i < 65536; i++) beat1(1'b1, 1'b0, 8'(i));
      gap(1);
      chk_i("sat_reach", int'(bus1.ov_err_cnt), 65535);
      beat1(1'b1, 1'b0, 8'h00);
      gap(1);
      chk_i("sat_hold", int'(bus1.ov_err_cnt), 65535);
      chk_i("sat_hold_m", int'(busm.ov_err_cnt), m_err[1]);
      clear_q();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_splice_wide.md
Name: frame_splice_wide

Overview:
Parametrised byte-stream-to-word assembler for the network input frame parser. It packs IN_BYTES-wide input beats, delimited by explicit SOP/EOP, into OUT_BYTES-wide packet words with a 2-bit position flag and an invalid-byte count. It tolerates input gaps and single-word packets, and truncates oversize or interrupted packets with an error marker.

Parameters:
IN_BYTES, 1, bytes per input beat; power of 2 that divides OUT_BYTES.
OUT_BYTES, 16, bytes per output word; power of 2, at least 2.
MAX_PKT_BYTES, 2047, maximum accepted packet length in bytes.
Derived: IW = $clog2(OUT_BYTES); EW = max(1,$clog2(IN_BYTES)); PKT_W = 2+IW+8*OUT_BYTES (134 at defaults).

Ports:
clk_sys  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
i_data_wr  in  1  input beat valid
i_sop  in  1  first beat of packet (qualified by i_data_wr)
i_eop  in  1  last beat of packet (qualified by i_data_wr)
iv_data  in  8*IN_BYTES  beat bytes; byte 0 in MSBs
iv_empty  in  EW  invalid trailing (LSB-side) bytes on the EOP beat; ignored otherwise
o_pkt_wr  out  1  output word valid, one-cycle pulse
ov_pkt  out  PKT_W  [PKT_W-1:PKT_W-2] flag, [PKT_W-3:8*OUT_BYTES] invalid-byte count, data below; first byte in MSBs
o_pkt_err  out  1  qualifies a tail word of a truncated packet
ov_err_cnt  out  16  errored-packet count, saturating at 16'hFFFF
ov_state  out  2  FSM state for debug

Behaviour:
- Reset, asynchronous: all outputs 0, FSM IDLE, accumulator, fill pointer and byte counter 0.
- Flags: 01 head, 11 middle, 10 tail, 00 single-word packet (head and tail).
- Storage: a separate accumulator and output register. The output is registered; a word appears the cycle after the beat that completes it.
- Beats never straddle words, because IN_BYTES divides OUT_BYTES. Fill pointer advances by IN_BYTES and wraps to 0 on a full word.
- i_data_wr=0: all state holds in every state. A gap is not an error. o_pkt_wr=0.
- States:
  - IDLE (00): beats without i_sop are ignored. On i_sop, load the beat at fill 0, set head_pending, byte_cnt=IN_BYTES, go TRAN. If i_eop is also set, emit immediately (flag 00) and stay IDLE.
  - TRAN (01): on a non-SOP beat, write its bytes at the fill pointer.
    - Word full and no EOP: emit with flag 01 if head_pending, else 11; invalid=0; clear head_pending.
    - EOP: emit with flag 10, or 00 if head_pending. valid = fill + IN_BYTES - iv_empty; invalid = OUT_BYTES - valid. Unused bytes are 0. Go IDLE.
  - DISCARD (10): drop beats until an EOP beat, then go IDLE. An SOP beat in DISCARD starts a new packet exactly as in IDLE.
- Truncation:
  - Triggers: i_sop seen in TRAN, or byte_cnt + beat bytes > MAX_PKT_BYTES.
  - Response: emit a tail word (flag 10) of the pending bytes with o_pkt_err=1. If no bytes are pending, emit a zero word with invalid=OUT_BYTES-1. Increment ov_err_cnt.
  - Next state: an SOP-in-TRAN truncation loads the new SOP beat into the cleared accumulator in the same cycle and stays TRAN. An oversize truncation drops the offending beat and goes DISCARD, or IDLE if that beat carried EOP.
- If a beat completes a word and also triggers truncation, truncation wins. The beat is not written.
- byte_cnt is $clog2(MAX_PKT_BYTES+1)+1 bits wide so the comparison cannot overflow.
- Reset mid-packet: all state is cleared. A partial word is never emitted.

Decomposition:
- Package frame_splice_pkg: flag constants FLAG_HEAD/MID/TAIL/SINGLE, state encodings, PKT_W/IW derivation functions.
- One sub-module, splice_lane_mux: combinational write of an IN_BYTES beat into an OUT_BYTES accumulator at the fill pointer, plus zero-masking of invalid bytes on tail.

Test Plan:
1. IN_BYTES=1, 64-byte packet 0x00..0x3F, SOP on byte 0, EOP on byte 63 -> 4 words, flags 01,11,11,10, invalid 0 each; first word data 0x000102..0F.
2. IN_BYTES=1, 20-byte packet -> head word (flag 01, invalid 0), then tail (flag 10, invalid 12, low 12 bytes zero); 5-byte packet -> one word, flag 00, invalid 11.
3. IN_BYTES=4, 5 beats, i_data_wr low 3 cycles between beats 2 and 3, last iv_empty=2 (18 bytes) -> flag 01 invalid 0, then flag 10 invalid 14; gaps cause no error.
4. IN_BYTES=1, SOP after 20 bytes of packet A -> A tail (flag 10, invalid 12, o_pkt_err=1), ov_err_cnt=1; packet B (16 bytes) -> single word, flag 00, invalid 0, err 0.
5. MAX_PKT_BYTES=64, 80-byte packet -> flags 01,11,11,11; on byte 65, zero word flag 10, invalid 15, o_pkt_err=1; bytes 65-80 dropped, IDLE after EOP, ov_err_cnt+1.
6. reset_n low mid-packet after 9 bytes -> no output, ov_state=00. ov_err_cnt preset to 16'hFFFF then one truncation -> stays 16'hFFFF.
